// File: rtl/pp_level_accumulator_pkg.sv
// Shared definitions for the L4 level accumulator: FSM encoding and the
// partial-product vector geometry also used by the partial-product generator.
package pp_level_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int LVL_W = 4;

  // Total bits occupied by levels 1..n of a PP vector.
  function automatic int pp_length(input int m, input int n);
    return (m + 1) * n - (n * (n + 1)) / 2;
  endfunction

  function automatic int seg_width(input int m, input int j);
    return m - j + 1;
  endfunction

  // MSB index of level j inside a vector holding max_level levels.
  function automatic int seg_hi(input int m, input int max_level, input int j);
    return pp_length(m, max_level) - 1 - pp_length(m, j - 1);
  endfunction

  function automatic int seg_shift(input int m, input int j);
    return m + 1 - 2 * j;
  endfunction

endpackage

// File: rtl/pp_level_accumulator_segment_mux.sv
// Picks the level-lvl segment out of a concatenated PP vector and returns it
// zero-extended and shifted to its weight in the 2M+2-bit product.
module pp_segment_mux
  import pp_level_accumulator_pkg::*;
#(
  parameter  int MANTISSA_WIDTH = 23,
  parameter  int MAX_LEVEL      = 9,
  localparam int PP_LEN         = pp_length(MANTISSA_WIDTH, MAX_LEVEL),
  localparam int PROD_W         = 2 * MANTISSA_WIDTH + 2
) (
  input  logic [PP_LEN-1:0] pp_i,
  input  logic [LVL_W-1:0]  lvl_i,
  output logic [PROD_W-1:0] seg_o
);

  logic [PROD_W-1:0] aligned [1:MAX_LEVEL];

  for (genvar j = 1; j <= MAX_LEVEL; j++) begin : g_level
    localparam int W  = seg_width(MANTISSA_WIDTH, j);
    localparam int HI = seg_hi(MANTISSA_WIDTH, MAX_LEVEL, j);
    localparam int SH = seg_shift(MANTISSA_WIDTH, j);
    assign aligned[j] = PROD_W'(pp_i[HI -: W]) << SH;
  end

  // NOTE: seg_o gets a default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    seg_o = '0;
    for (int j = 1; j <= MAX_LEVEL; j++) begin
      if (lvl_i == LVL_W'(j)) seg_o = aligned[j];
    end
  end

endmodule

// File: rtl/pp_level_accumulator.sv
// Sums the per-level partial products onto 1 + X + Y, one level per cycle,
// producing the approximate (1.X)*(1.Y) mantissa product.
module pp_level_accumulator
  import pp_level_accumulator_pkg::*;
#(
  parameter  int MANTISSA_WIDTH = 23,
  parameter  int MAX_LEVEL      = 9,
  localparam int PP_LEN         = pp_length(MANTISSA_WIDTH, MAX_LEVEL),
  localparam int PROD_W         = 2 * MANTISSA_WIDTH + 2
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      In_Valid,
  output logic                      In_Ready,
  input  logic [MANTISSA_WIDTH-1:0] Mantissa_X,
  input  logic [MANTISSA_WIDTH-1:0] Mantissa_Y,
  input  logic [PP_LEN-1:0]         Partial_Product_X,
  input  logic [PP_LEN-1:0]         Partial_Product_Y,
  input  logic [LVL_W-1:0]          Level_Cfg,
  output logic                      Out_Valid,
  input  logic                      Out_Ready,
  output logic [PROD_W-1:0]         Product
);

  localparam int M = MANTISSA_WIDTH;

  state_e              state_q, state_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [LVL_W-1:0]    cfg_q, cfg_d;
  logic [PP_LEN-1:0]   ppx_q, ppx_d;
  logic [PP_LEN-1:0]   ppy_q, ppy_d;
  logic [PROD_W-1:0]   acc_q, acc_d;

  logic [LVL_W-1:0]    cfg_clamped;
  logic [PROD_W-1:0]   seg_x, seg_y;
  logic [PROD_W-1:0]   add_a, add_b, add_c, acc_sum;

  assign cfg_clamped = (Level_Cfg > LVL_W'(MAX_LEVEL)) ? LVL_W'(MAX_LEVEL) : Level_Cfg;

  pp_segment_mux #(
    .MANTISSA_WIDTH (MANTISSA_WIDTH),
    .MAX_LEVEL      (MAX_LEVEL)
  ) u_seg_x (
    .pp_i  (ppx_q),
    .lvl_i (lvl_q),
    .seg_o (seg_x)
  );

  pp_segment_mux #(
    .MANTISSA_WIDTH (MANTISSA_WIDTH),
    .MAX_LEVEL      (MAX_LEVEL)
  ) u_seg_y (
    .pp_i  (ppy_q),
    .lvl_i (lvl_q),
    .seg_o (seg_y)
  );

  // The single 3-input adder builds the base term in IDLE and adds one level per ACCUM cycle.
  always_comb begin
    if (state_q == ST_IDLE) begin
      add_a = PROD_W'(1) << (2 * M);
      add_b = PROD_W'(Mantissa_X) << M;
      add_c = PROD_W'(Mantissa_Y) << M;
    end else begin
      add_a = acc_q;
      add_b = seg_x;
      add_c = seg_y;
    end
  end

  assign acc_sum = add_a + add_b + add_c;

  // FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (In_Valid) state_d = (cfg_clamped == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (lvl_q == cfg_q) state_d = ST_DONE;
      ST_DONE:  if (Out_Ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    unique case (state_q)
      ST_IDLE: In_Ready  = 1'b1;
      ST_DONE: Out_Valid = 1'b1;
      default: ;
    endcase
    Product = Out_Valid ? acc_q : '0;
  end

  // Datapath next state: inputs are captured only on the accept cycle.
  always_comb begin
    lvl_d = lvl_q;
    cfg_d = cfg_q;
    ppx_d = ppx_q;
    ppy_d = ppy_q;
    acc_d = acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (In_Valid) begin
          ppx_d = Partial_Product_X;
          ppy_d = Partial_Product_Y;
          cfg_d = cfg_clamped;
          acc_d = acc_sum;
          lvl_d = LVL_W'(1);
        end
      end
      ST_ACCUM: begin
        acc_d = acc_sum;
        if (lvl_q != cfg_q) lvl_d = lvl_q + LVL_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: the capture registers are reset too, so a reset mid-operation leaves no stale operands behind.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lvl_q <= '0;
      cfg_q <= '0;
      ppx_q <= '0;
      ppy_q <= '0;
      acc_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      cfg_q <= cfg_d;
      ppx_q <= ppx_d;
      ppy_q <= ppy_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_pp_level_accumulator.sv
// Directed bench for pp_level_accumulator: a small M=4/MAX_LEVEL=2 instance
// with hand-computed results and a default-parameter instance against a model.
module tb_pp_level_accumulator;

  localparam int TIMEOUT = 40;

  logic clk;
  logic rst_n;

  // Small instance: M=4, MAX_LEVEL=2, PP_LEN=7, Product 10 bits
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [3:0] s_x, s_y, s_cfg;
  logic [6:0] s_ppx, s_ppy;
  logic [9:0] s_product;

  // Default instance: M=23, MAX_LEVEL=9, PP_LEN=171, Product 48 bits
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [22:0]  b_x, b_y;
  logic [3:0]   b_cfg;
  logic [170:0] b_ppx, b_ppy;
  logic [47:0]  b_product;

  int checks = 0;
  int errors = 0;

  pp_level_accumulator #(
    .MANTISSA_WIDTH (4),
    .MAX_LEVEL      (2)
  ) dut_small (
    .Clk               (clk),
    .Rst_n             (rst_n),
    .In_Valid          (s_in_valid),
    .In_Ready          (s_in_ready),
    .Mantissa_X        (s_x),
    .Mantissa_Y        (s_y),
    .Partial_Product_X (s_ppx),
    .Partial_Product_Y (s_ppy),
    .Level_Cfg         (s_cfg),
    .Out_Valid         (s_out_valid),
    .Out_Ready         (s_out_ready),
    .Product           (s_product)
  );

  pp_level_accumulator dut_big (
    .Clk               (clk),
    .Rst_n             (rst_n),
    .In_Valid          (b_in_valid),
    .In_Ready          (b_in_ready),
    .Mantissa_X        (b_x),
    .Mantissa_Y        (b_y),
    .Partial_Product_X (b_ppx),
    .Partial_Product_Y (b_ppy),
    .Level_Cfg         (b_cfg),
    .Out_Valid         (b_out_valid),
    .Out_Ready         (b_out_ready),
    .Product           (b_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Walks the vector MSB-first with a running offset, one segment per level.
  function automatic logic [47:0] big_model(input logic [22:0] x, input logic [22:0] y,
                                            input logic [170:0] ppx, input logic [170:0] ppy,
                                            input int cfg);
    logic [47:0] acc, sx, sy;
    int top, w, n;
    n   = (cfg > 9) ? 9 : cfg;
    acc = (48'd1 << 46) + ({25'd0, x} << 23) + ({25'd0, y} << 23);
    top = 171;
    for (int j = 1; j <= n; j++) begin
      w  = 24 - j;
      sx = '0;
      sy = '0;
      for (int b = 0; b < w; b++) begin
        sx[b] = ppx[top - w + b];
        sy[b] = ppy[top - w + b];
      end
      top = top - w;
      acc = acc + ((sx + sy) << (24 - 2 * j));
    end
    return acc;
  endfunction

  // Called #1 after a rising edge with the small DUT idle; returns it to idle.
  task automatic run_small(input logic [3:0] x, input logic [3:0] y,
                           input logic [6:0] ppx, input logic [6:0] ppy,
                           input logic [3:0] cfg, output int lat, output logic [9:0] prod);
    s_x = x; s_y = y; s_ppx = ppx; s_ppy = ppy; s_cfg = cfg;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_x = ~x; s_y = ~y; s_ppx = ~ppx; s_ppy = ~ppy; s_cfg = 4'd0;
    lat = 1;
    while (s_out_valid !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = s_product;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  task automatic run_big(input logic [22:0] x, input logic [22:0] y,
                         input logic [170:0] ppx, input logic [170:0] ppy,
                         input logic [3:0] cfg, output int lat, output logic [47:0] prod);
    b_x = x; b_y = y; b_ppx = ppx; b_ppy = ppy; b_cfg = cfg;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_x = ~x; b_y = ~y; b_ppx = ~ppx; b_ppy = ~ppy; b_cfg = 4'd0;
    lat = 1;
    while (b_out_valid !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = b_product;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_product !== 10'd0) begin
      errors++;
      $display("FAIL reset_small: in_ready=%b out_valid=%b product=%0d, want 1 0 0",
               s_in_ready, s_out_valid, s_product);
    end
    checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_product !== 48'd0) begin
      errors++;
      $display("FAIL reset_big: in_ready=%b out_valid=%b product=%0h, want 1 0 0",
               b_in_ready, b_out_valid, b_product);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_base;
    int lat;
    logic [9:0] prod;
    run_small(4'd0, 4'd0, 7'h00, 7'h00, 4'd0, lat, prod);
    checks++;
    if (prod !== 10'd256 || lat != 1) begin
      errors++;
      $display("FAIL base_only: product=%0d latency=%0d, want 256 1", prod, lat);
    end
    run_small(4'd8, 4'd8, 7'h00, 7'h00, 4'd0, lat, prod);
    checks++;
    if (prod !== 10'd512 || lat != 1) begin
      errors++;
      $display("FAIL base_terms: product=%0d latency=%0d, want 512 1", prod, lat);
    end
  endtask

  task automatic test_all_levels;
    int lat;
    logic [9:0] prod;
    run_small(4'd0, 4'd0, 7'h7F, 7'h7F, 4'd2, lat, prod);
    checks++;
    if (prod !== 10'd524 || lat != 3) begin
      errors++;
      $display("FAIL all_levels: product=%0d latency=%0d, want 524 3", prod, lat);
    end
  endtask

  task automatic test_clamp;
    int lat;
    logic [9:0] prod;
    run_small(4'd0, 4'd0, 7'h7F, 7'h7F, 4'd9, lat, prod);
    checks++;
    if (prod !== 10'd524 || lat != 3) begin
      errors++;
      $display("FAIL clamp_9: product=%0d latency=%0d, want 524 3", prod, lat);
    end
    run_small(4'd0, 4'd0, 7'h7F, 7'h7F, 4'd15, lat, prod);
    checks++;
    if (prod !== 10'd524 || lat != 3) begin
      errors++;
      $display("FAIL clamp_15: product=%0d latency=%0d, want 524 3", prod, lat);
    end
  endtask

  // PPX seg1=10 seg2=7, PPY seg1=1 seg2=5; X=3, Y=5: base 384, level1 +88, level2 +24
  task automatic test_partial_levels;
    int lat;
    logic [9:0] prod;
    run_small(4'd3, 4'd5, 7'h57, 7'h0D, 4'd1, lat, prod);
    checks++;
    if (prod !== 10'd472 || lat != 2) begin
      errors++;
      $display("FAIL one_level: product=%0d latency=%0d, want 472 2", prod, lat);
    end
    run_small(4'd3, 4'd5, 7'h57, 7'h0D, 4'd2, lat, prod);
    checks++;
    if (prod !== 10'd496 || lat != 3) begin
      errors++;
      $display("FAIL two_levels: product=%0d latency=%0d, want 496 3", prod, lat);
    end
  endtask

  task automatic test_backpressure;
    s_x = 4'd8; s_y = 4'd0; s_ppx = 7'h00; s_ppy = 7'h00; s_cfg = 4'd0;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_x = 4'd1; s_y = 4'd2;
    checks++;
    if (s_out_valid !== 1'b1 || s_product !== 10'd384) begin
      errors++;
      $display("FAIL bp_first: out_valid=%b product=%0d, want 1 384", s_out_valid, s_product);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (s_out_valid !== 1'b1 || s_product !== 10'd384 || s_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b product=%0d in_ready=%b, want 1 384 0",
                 i, s_out_valid, s_product, s_in_ready);
      end
    end
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", s_out_valid, s_in_ready);
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b1 || s_product !== 10'd304) begin
      errors++;
      $display("FAIL bp_second: out_valid=%b product=%0d, want 1 304", s_out_valid, s_product);
    end
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [9:0] prod;
    s_x = 4'd0; s_y = 4'd0; s_ppx = 7'h7F; s_ppy = 7'h7F; s_cfg = 4'd2;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_product !== 10'd0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b product=%0d in_ready=%b, want 0 0 1",
               s_out_valid, s_product, s_in_ready);
    end
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after: out_valid=%b in_ready=%b, want 0 1", s_out_valid, s_in_ready);
    end
    run_small(4'd3, 4'd5, 7'h57, 7'h0D, 4'd2, lat, prod);
    checks++;
    if (prod !== 10'd496 || lat != 3) begin
      errors++;
      $display("FAIL reset_mid_recover: product=%0d latency=%0d, want 496 3", prod, lat);
    end
  endtask

  task automatic test_default_params;
    logic [191:0] rx, ry;
    logic [22:0]  x, y;
    logic [47:0]  prod, exp_prod;
    logic [3:0]   cfg_tab [5];
    int           lat, exp_lat;
    cfg_tab[0] = 4'd9;
    cfg_tab[1] = 4'd5;
    cfg_tab[2] = 4'd12;
    cfg_tab[3] = 4'd0;
    cfg_tab[4] = 4'd1;
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 6; k++) begin
        rx[k*32 +: 32] = $urandom;
        ry[k*32 +: 32] = $urandom;
      end
      x = 23'($urandom);
      y = 23'($urandom);
      exp_prod = big_model(x, y, rx[170:0], ry[170:0], int'(cfg_tab[t]));
      exp_lat  = ((cfg_tab[t] > 4'd9) ? 9 : int'(cfg_tab[t])) + 1;
      run_big(x, y, rx[170:0], ry[170:0], cfg_tab[t], lat, prod);
      checks++;
      if (prod !== exp_prod || lat != exp_lat) begin
        errors++;
        $display("FAIL default_rand[%0d]: product=%h latency=%0d, want %h %0d",
                 t, prod, lat, exp_prod, exp_lat);
      end
    end
    rx = '1;
    exp_prod = big_model('1, '1, rx[170:0], rx[170:0], 9);
    run_big('1, '1, rx[170:0], rx[170:0], 4'd9, lat, prod);
    checks++;
    if (prod !== exp_prod || lat != 10) begin
      errors++;
      $display("FAIL default_all_ones: product=%h latency=%0d, want %h 10", prod, lat, exp_prod);
    end
  endtask

  initial begin
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_x = '0; s_y = '0; s_ppx = '0; s_ppy = '0; s_cfg = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_x = '0; b_y = '0; b_ppx = '0; b_ppy = '0; b_cfg = '0;
    rst_n = 1'b1;
    #1;
    test_reset();
    test_base();
    test_all_levels();
    test_clamp();
    test_partial_levels();
    test_backpressure();
    test_reset_mid();
    test_default_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
